// File: rtl/resource_arbiter.sv
// Round-robin arbiter feeding one shared fixed-latency resource; tags each issue and
// steers every returning result back to the requester that issued it.
module resource_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 32,
    parameter int RES_LATENCY = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        arbiter_req,
    input  logic [NUM_REQ*DATA_W-1:0] resource_input,
    output logic [NUM_REQ-1:0]        arbiter_grant,
    input  logic                      res_ready,
    output logic [DATA_W-1:0]         res_in_data,
    output logic                      res_in_valid,
    input  logic [DATA_W-1:0]         res_out_data,
    input  logic                      res_out_valid,
    output logic [NUM_REQ*DATA_W-1:0] resource_output,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic                      busy,
    output logic                      err_sticky
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0]        ptr_reg;
    logic [ID_W-1:0]        issue_id_reg;
    logic [ID_W-1:0]        grant_id;
    logic                   grant_any;
    logic [ID_W:0]          scan_idx;
    logic [RES_LATENCY-1:0] tag_valid_reg;
    logic [ID_W-1:0]        tag_id_reg [RES_LATENCY];
    logic                   last_valid;
    logic [ID_W-1:0]        last_id;

    // Scan from the pointer upward, wrapping at NUM_REQ; first requester found wins.
    always_comb begin
        arbiter_grant = '0;
        grant_id      = '0;
        grant_any     = 1'b0;
        scan_idx      = '0;
        if (reset && res_ready) begin
            for (int o = 0; o < NUM_REQ; o++) begin
                scan_idx = {1'b0, ptr_reg} + (ID_W+1)'(o);
                if (scan_idx >= (ID_W+1)'(NUM_REQ)) begin
                    scan_idx = scan_idx - (ID_W+1)'(NUM_REQ);
                end
                if (!grant_any && arbiter_req[scan_idx[ID_W-1:0]]) begin
                    grant_any = 1'b1;
                    grant_id  = scan_idx[ID_W-1:0];
                end
            end
            if (grant_any) begin
                arbiter_grant[grant_id] = 1'b1;
            end
        end
    end

    assign last_valid = tag_valid_reg[RES_LATENCY-1];
    assign last_id    = tag_id_reg[RES_LATENCY-1];
    assign busy       = res_in_valid | (|tag_valid_reg);

    // The issue register is the head of the tag pipe; RES_LATENCY further stages
    // bring the tag level with the result, which appears RES_LATENCY cycles after issue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_reg         <= '0;
            issue_id_reg    <= '0;
            res_in_valid    <= 1'b0;
            res_in_data     <= '0;
            tag_valid_reg   <= '0;
            for (int i = 0; i < RES_LATENCY; i++) begin
                tag_id_reg[i] <= '0;
            end
            rsp_valid       <= '0;
            resource_output <= '0;
            err_sticky      <= 1'b0;
        end else begin
            res_in_valid <= grant_any;
            if (grant_any) begin
                res_in_data  <= resource_input[int'(grant_id)*DATA_W +: DATA_W];
                issue_id_reg <= grant_id;
                ptr_reg      <= (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
            end

            tag_valid_reg[0] <= res_in_valid;
            tag_id_reg[0]    <= issue_id_reg;
            for (int i = 1; i < RES_LATENCY; i++) begin
                tag_valid_reg[i] <= tag_valid_reg[i-1];
                tag_id_reg[i]    <= tag_id_reg[i-1];
            end

            rsp_valid <= '0;
            if (last_valid && res_out_valid) begin
                rsp_valid[last_id] <= 1'b1;
                resource_output[int'(last_id)*DATA_W +: DATA_W] <= res_out_data;
            end else if (last_valid != res_out_valid) begin
                err_sticky <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_resource_arbiter.sv
// Bench for resource_arbiter: directed scenarios with literal expectations plus random
// traffic, all checked every cycle against a cycle-history model of issues and results.
module tb_resource_arbiter;
    localparam int N = 4;
    localparam int W = 32;
    localparam int L = 3;
    localparam int H = 64;
    typedef logic [N*W-1:0] cv_t;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   arbiter_req;
    logic [N*W-1:0] resource_input;
    logic [N-1:0]   arbiter_grant;
    logic           res_ready;
    logic [W-1:0]   res_in_data;
    logic           res_in_valid;
    logic [W-1:0]   res_out_data;
    logic           res_out_valid;
    logic [N*W-1:0] resource_output;
    logic [N-1:0]   rsp_valid;
    logic           busy;
    logic           err_sticky;

    resource_arbiter #(.NUM_REQ(N), .DATA_W(W), .RES_LATENCY(L)) dut (
        .clk(clk), .reset(reset), .arbiter_req(arbiter_req), .resource_input(resource_input),
        .arbiter_grant(arbiter_grant), .res_ready(res_ready), .res_in_data(res_in_data),
        .res_in_valid(res_in_valid), .res_out_data(res_out_data), .res_out_valid(res_out_valid),
        .resource_output(resource_output), .rsp_valid(rsp_valid), .busy(busy),
        .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic late = 1'b0;

    // Model: per-cycle history of what was granted and what the resource returned.
    logic [N-1:0] last_grant = '0;
    int           mptr = 0;
    logic         exp_err = 1'b0;
    logic         g_v [H];
    int           g_k [H];
    logic [W-1:0] g_d [H];
    logic         ro_v [H];
    logic [W-1:0] exp_out [N];
    // Resource stub: results scheduled by due cycle.
    logic         sv [H];
    logic [W-1:0] sd [H];

    function automatic int hix(input int c);
        return ((c % H) + H) % H;
    endfunction

    function automatic logic [N-1:0] rr_pick(input logic [N-1:0] req, input int p);
        logic [N-1:0] one;
        one = 1;
        for (int o = 0; o < N; o++) begin
            if (req[(p + o) % N]) return one << ((p + o) % N);
        end
        return '0;
    endfunction

    task automatic chk(input string name, input cv_t act, input cv_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        int due;
        @(posedge clk);
        #1;
        cyc++;
        if (res_in_valid === 1'b1) begin
            due = cyc + L + (late ? 1 : 0);
            sv[hix(due)] = 1'b1;
            sd[hix(due)] = res_in_data;
        end
        res_out_valid = sv[hix(cyc)];
        res_out_data  = sd[hix(cyc)];
        sv[hix(cyc)]  = 1'b0;
    endtask

    task automatic set_data(input int i, input logic [W-1:0] v);
        resource_input[i*W +: W] = v;
    endtask

    task automatic idle(input int k);
        arbiter_req = '0;
        repeat (k) tick();
    endtask

    task automatic rand_update();
        for (int i = 0; i < N; i++) begin
            if (last_grant[i]) begin
                arbiter_req[i] = 1'($urandom_range(0, 1));
                set_data(i, $urandom);
            end else if (arbiter_req[i]) begin
                if ($urandom_range(0, 15) == 0) arbiter_req[i] = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                arbiter_req[i] = 1'b1;
                set_data(i, $urandom);
            end
        end
        res_ready = ($urandom_range(0, 3) != 0);
    endtask

    always @(negedge clk) begin : compare
        logic [N-1:0] eg;
        logic [N-1:0] er;
        cv_t          eo;
        logic         eb;
        int           t;
        if (!reset) begin
            chk("rst_grant", cv_t'(arbiter_grant), '0);
            chk("rst_in_valid", cv_t'(res_in_valid), '0);
            chk("rst_rsp_valid", cv_t'(rsp_valid), '0);
            chk("rst_output", resource_output, '0);
            chk("rst_busy", cv_t'(busy), '0);
            chk("rst_err", cv_t'(err_sticky), '0);
            for (int i = 0; i < H; i++) begin
                g_v[i]  = 1'b0;
                ro_v[i] = 1'b0;
            end
            for (int i = 0; i < N; i++) exp_out[i] = '0;
            exp_err    = 1'b0;
            mptr       = 0;
            last_grant = '0;
        end else begin
            eg = res_ready ? rr_pick(arbiter_req, mptr) : '0;
            chk("grant", cv_t'(arbiter_grant), cv_t'(eg));
            chk("issue_valid", cv_t'(res_in_valid), cv_t'(g_v[hix(cyc-1)]));
            if (g_v[hix(cyc-1)]) chk("issue_data", cv_t'(res_in_data), cv_t'(g_d[hix(cyc-1)]));
            t  = hix(cyc - L - 2);
            er = '0;
            if (g_v[t] && ro_v[hix(cyc-1)]) begin
                er[g_k[t]]      = 1'b1;
                exp_out[g_k[t]] = g_d[t];
            end
            chk("rsp_valid", cv_t'(rsp_valid), cv_t'(er));
            for (int i = 0; i < N; i++) eo[i*W +: W] = exp_out[i];
            chk("resource_output", resource_output, eo);
            chk("err_sticky", cv_t'(err_sticky), cv_t'(exp_err));
            eb = 1'b0;
            for (int j = 1; j <= L + 1; j++) eb |= g_v[hix(cyc-j)];
            chk("busy", cv_t'(busy), cv_t'(eb));
            if (g_v[hix(cyc-L-1)] != res_out_valid) exp_err = 1'b1;
            ro_v[hix(cyc)] = res_out_valid;
            g_v[hix(cyc)]  = |eg;
            for (int k = 0; k < N; k++) begin
                if (eg[k]) begin
                    g_k[hix(cyc)] = k;
                    g_d[hix(cyc)] = resource_input[k*W +: W];
                    mptr = (k + 1) % N;
                end
            end
            last_grant = eg;
        end
    end

    initial begin
        for (int i = 0; i < H; i++) begin
            g_v[i] = 1'b0; g_k[i] = 0; g_d[i] = '0; ro_v[i] = 1'b0;
            sv[i] = 1'b0; sd[i] = '0;
        end
        for (int i = 0; i < N; i++) exp_out[i] = '0;
        reset = 1'b0; arbiter_req = '0; resource_input = '0; res_ready = 1'b1;
        res_out_valid = 1'b0; res_out_data = '0;

        repeat (3) tick();
        @(negedge clk);
        chk("reset_busy_lit", cv_t'(busy), '0);
        tick();
        reset = 1'b1;
        idle(2);

        // All four held high from ptr=0: grants and responses rotate 0,1,2,3,...
        arbiter_req = 4'hF;
        for (int i = 0; i < N; i++) set_data(i, 32'h1000_0000 + i);
        for (int j = 0; j <= 12; j++) begin
            @(negedge clk);
            if (j < 8) chk("rr_grant_lit", cv_t'(arbiter_grant), cv_t'(4'b0001 << (j % 4)));
            if (j >= L + 2) chk("rr_rsp_lit", cv_t'(rsp_valid), cv_t'(4'b0001 << ((j - L - 2) % 4)));
            tick();
            if (j == 7) arbiter_req = '0;
            else if (j < 7) set_data(j % 4, 32'h2000_0000 + j);
        end
        idle(4);

        // Requesters 1 and 3: after 1 is served the pointer passes 2 and lands on 3.
        arbiter_req = 4'b1010;
        @(negedge clk);
        chk("wrap_first_lit", cv_t'(arbiter_grant), cv_t'(4'b0010));
        tick();
        set_data(1, 32'h3000_0001);
        @(negedge clk);
        chk("wrap_second_lit", cv_t'(arbiter_grant), cv_t'(4'b1000));
        tick();
        idle(6);

        // Single request, echoing resource: response five cycles after grant.
        arbiter_req = 4'b0100;
        set_data(2, 32'hA5A5_0002);
        @(negedge clk);
        chk("single_grant_lit", cv_t'(arbiter_grant), cv_t'(4'b0100));
        tick();
        arbiter_req = '0;
        @(negedge clk);
        chk("single_issue_lit", cv_t'(res_in_valid), cv_t'(1'b1));
        chk("single_issue_data_lit", cv_t'(res_in_data), cv_t'(32'hA5A5_0002));
        repeat (4) tick();
        @(negedge clk);
        chk("single_rsp_lit", cv_t'(rsp_valid), cv_t'(4'b0100));
        chk("single_out_lit", cv_t'(resource_output[2*W +: W]), cv_t'(32'hA5A5_0002));
        tick();
        idle(4);

        // Resource not ready: no grant, no issue; grant on the same cycle ready returns.
        res_ready   = 1'b0;
        arbiter_req = 4'b0001;
        set_data(0, 32'h4000_0000);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk("stall_grant_lit", cv_t'(arbiter_grant), '0);
            chk("stall_issue_lit", cv_t'(res_in_valid), '0);
            tick();
        end
        res_ready = 1'b1;
        @(negedge clk);
        chk("stall_release_lit", cv_t'(arbiter_grant), cv_t'(4'b0001));
        tick();
        idle(6);

        // Result arriving one cycle late: error flag, no response, flag sticks.
        late        = 1'b1;
        arbiter_req = 4'b0001;
        set_data(0, 32'h5000_0000);
        tick();
        late        = 1'b0;
        arbiter_req = '0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            chk("late_no_rsp_lit", cv_t'(rsp_valid), '0);
            tick();
        end
        @(negedge clk);
        chk("late_err_lit", cv_t'(err_sticky), cv_t'(1'b1));
        idle(3);
        @(negedge clk);
        chk("late_err_hold_lit", cv_t'(err_sticky), cv_t'(1'b1));
        tick();

        // Reset with three tags in flight, then a clean service of requester 1.
        arbiter_req = 4'b0111;
        for (int i = 0; i < 3; i++) set_data(i, 32'h6000_0000 + i);
        repeat (3) begin
            tick();
            arbiter_req &= ~last_grant;
        end
        @(negedge clk);
        chk("inflight_busy_lit", cv_t'(busy), cv_t'(1'b1));
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("midreset_busy_lit", cv_t'(busy), '0);
        chk("midreset_err_lit", cv_t'(err_sticky), '0);
        repeat (8) tick();
        reset       = 1'b1;
        arbiter_req = 4'b0010;
        set_data(1, 32'h7000_0001);
        @(negedge clk);
        chk("post_reset_grant_lit", cv_t'(arbiter_grant), cv_t'(4'b0010));
        tick();
        arbiter_req = '0;
        repeat (4) tick();
        @(negedge clk);
        chk("post_reset_rsp_lit", cv_t'(rsp_valid), cv_t'(4'b0010));
        chk("post_reset_out_lit", cv_t'(resource_output[W +: W]), cv_t'(32'h7000_0001));
        tick();
        idle(4);

        // Random traffic against the model.
        repeat (600) begin
            tick();
            rand_update();
        end
        res_ready = 1'b1;
        idle(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
